// File: rtl/arbitro_alu.sv
// Two-port arbiter/sequencer for the shared 8-bit ALU: grants one requester at a time,
// registers ALU inputs, captures the result and returns it over valid/ready.
// Define ARBITRO_ALU_ROUND_ROBIN_EN for round-robin; default build is fixed priority (port 0).
module arbitro_alu (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [1:0]  req_valid,
  output logic [1:0]  req_ready,
  input  logic [7:0]  req_a0,
  input  logic [7:0]  req_b0,
  input  logic [7:0]  req_a1,
  input  logic [7:0]  req_b1,
  input  logic [3:0]  req_op0,
  input  logic [3:0]  req_op1,
  output logic [1:0]  resp_valid,
  input  logic [1:0]  resp_ready,
  output logic [7:0]  resp_res,
  output logic        resp_carry,
  output logic        resp_zero,
  output logic [7:0]  alu_a,
  output logic [7:0]  alu_b,
  output logic [3:0]  alu_op,
  input  logic [7:0]  alu_res,
  input  logic        alu_carry,
  input  logic        alu_zero,
  output logic [15:0] ops_concluidas
);

  typedef enum logic [1:0] {
    OCIOSO   = 2'd0,
    EXECUTA  = 2'd1,
    RESPONDE = 2'd2
  } estado_t;

  estado_t     r_estado;
  logic        r_ultimo;
  logic        r_dono;
  logic [7:0]  r_alu_a;
  logic [7:0]  r_alu_b;
  logic [3:0]  r_alu_op;
  logic [7:0]  r_resp_res;
  logic        r_resp_carry;
  logic        r_resp_zero;
  logic [1:0]  r_resp_valid;
  logic [15:0] r_ops;

  logic        w_pref;
  logic        w_grant;
  logic        w_grant_valid;
  logic [1:0]  w_req_ready;

  // Port preferred under contention; fixed priority keeps tracking ultimo but always picks 0.
`ifdef ARBITRO_ALU_ROUND_ROBIN_EN
  assign w_pref = ~r_ultimo;
`else
  assign w_pref = r_ultimo & 1'b0;
`endif

  always_comb begin
    w_grant       = 1'b0;
    w_grant_valid = 1'b0;
    case (req_valid)
      2'b01: begin
        w_grant       = 1'b0;
        w_grant_valid = 1'b1;
      end
      2'b10: begin
        w_grant       = 1'b1;
        w_grant_valid = 1'b1;
      end
      2'b11: begin
        w_grant       = w_pref;
        w_grant_valid = 1'b1;
      end
      default: begin
        w_grant       = 1'b0;
        w_grant_valid = 1'b0;
      end
    endcase
  end

  always_comb begin
    w_req_ready = 2'b00;
    if ((r_estado == OCIOSO) && w_grant_valid) begin
      w_req_ready = w_grant ? 2'b10 : 2'b01;
    end else begin
      w_req_ready = 2'b00;
    end
  end

  // Sequencer: accept -> execute (capture ALU) -> respond until the owner consumes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado     <= OCIOSO;
      r_ultimo     <= 1'b1;
      r_dono       <= 1'b0;
      r_alu_a      <= 8'd0;
      r_alu_b      <= 8'd0;
      r_alu_op     <= 4'd0;
      r_resp_res   <= 8'd0;
      r_resp_carry <= 1'b0;
      r_resp_zero  <= 1'b0;
      r_resp_valid <= 2'b00;
      r_ops        <= 16'd0;
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (w_grant_valid) begin
            r_alu_a  <= w_grant ? req_a1 : req_a0;
            r_alu_b  <= w_grant ? req_b1 : req_b0;
            r_alu_op <= w_grant ? req_op1 : req_op0;
            r_dono   <= w_grant;
            r_ultimo <= w_grant;
            r_estado <= EXECUTA;
          end else begin
            r_estado <= OCIOSO;
          end
        end
        EXECUTA: begin
          r_resp_res   <= alu_res;
          r_resp_carry <= alu_carry;
          r_resp_zero  <= alu_zero;
          r_resp_valid <= r_dono ? 2'b10 : 2'b01;
          r_estado     <= RESPONDE;
        end
        RESPONDE: begin
          if (resp_ready[r_dono]) begin
            r_resp_valid <= 2'b00;
            r_ops        <= r_ops + 16'd1;
            r_estado     <= OCIOSO;
          end else begin
            r_estado <= RESPONDE;
          end
        end
        default: begin
          r_resp_valid <= 2'b00;
          r_estado     <= OCIOSO;
        end
      endcase
    end
  end

  assign req_ready      = w_req_ready;
  assign resp_valid     = r_resp_valid;
  assign resp_res       = r_resp_res;
  assign resp_carry     = r_resp_carry;
  assign resp_zero      = r_resp_zero;
  assign alu_a          = r_alu_a;
  assign alu_b          = r_alu_b;
  assign alu_op         = r_alu_op;
  assign ops_concluidas = r_ops;

endmodule
